fractal_pixel_engine: RTL

Parametrised successor to the fixed-resolution Mandelbrot pixel generator. It walks a parametrised X_SIZE×Y_SIZE frame and runs the escape-time iteration in signed fixed point, one iteration per clock, in either Mandelbrot or Julia mode. Per-frame configuration comes from the AXI-Lite register file: viewport origin, step, iteration limit, mode and Julia constant. Pixels are emitted as an AXI4-Stream video beat stream with SOF on tuser and EOL on tlast, feeding the VDMA/packer path.

---
 rtl/fractal_pixel_engine_if.sv | 27 ++
 rtl/fractal_pixel_engine.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fractal_pixel_engine_if.sv
// Pixel video stream: 32-bit beats with SOF on tuser and EOL on tlast.
interface fractal_pixel_engine_if;
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tlast;
    logic        tvalid;
    logic        tready;
    logic        tuser;

    modport master (
        output tdata,
        output tkeep,
        output tlast,
        output tvalid,
        output tuser,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tkeep,
        input  tlast,
        input  tvalid,
        input  tuser,
        output tready
    );
endinterface

// File: rtl/fractal_pixel_engine.sv
// Escape-time fractal generator: walks an X_SIZE x Y_SIZE frame, iterates
// z <- z^2 + c in signed fixed point (one step per clock, Mandelbrot or Julia)
// and streams one coloured pixel per beat.
module fractal_pixel_engine #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned FRAC_W = 24,
    parameter int unsigned X_SIZE = 640,
    parameter int unsigned Y_SIZE = 480,
    parameter int unsigned ITER_W = 8
) (
    input  logic                     out_stream_aclk,
    input  logic                     periph_resetn,
    input  logic                     enable,
    input  logic                     mode,
    input  logic [ITER_W-1:0]        max_iter,
    input  logic signed [DATA_W-1:0] origin_re,
    input  logic signed [DATA_W-1:0] origin_im,
    input  logic signed [DATA_W-1:0] step,
    input  logic signed [DATA_W-1:0] julia_re,
    input  logic signed [DATA_W-1:0] julia_im,
    fractal_pixel_engine_if.master   out_stream,
    output logic                     busy,
    output logic                     frame_done
);

    localparam int unsigned XW = (X_SIZE > 1) ? $clog2(X_SIZE) : 1;
    localparam int unsigned YW = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;
    localparam int unsigned PW = 2 * DATA_W;
    localparam int unsigned MW = DATA_W + 1;
    localparam logic [XW-1:0] X_LAST = XW'(X_SIZE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(Y_SIZE - 1);
    localparam logic signed [MW-1:0] ESC_LIM = MW'(4) <<< FRAC_W;

    typedef enum logic [1:0] {S_IDLE, S_INIT, S_ITER, S_OUT} state_e;

    state_e                    state_q, state_d;
    logic [XW-1:0]             x_q, x_d;
    logic [YW-1:0]             y_q, y_d;
    logic [ITER_W-1:0]         iter_q, iter_d;
    logic signed [DATA_W-1:0]  zr_q, zr_d, zi_q, zi_d, cr_q, cr_d, ci_q, ci_d;
    logic signed [DATA_W-1:0]  cre_acc_q, cre_acc_d, cim_acc_q, cim_acc_d;
    logic                      mode_q, mode_d;
    logic [ITER_W-1:0]         max_iter_q, max_iter_d;
    logic signed [DATA_W-1:0]  origin_re_q, origin_re_d, step_q, step_d;
    logic signed [DATA_W-1:0]  julia_re_q, julia_re_d, julia_im_q, julia_im_d;
    logic [31:0]               tdata_q, tdata_d;
    logic                      tvalid_q, tvalid_d, tlast_q, tlast_d, tuser_q, tuser_d;
    logic                      busy_q, busy_d, frame_done_q, frame_done_d;

    logic signed [DATA_W-1:0]  zr2_w, zi2_w, zri_w, zr_nxt_w, zi_nxt_w;
    logic signed [MW-1:0]      mag_w;
    logic                      escape_w;
    logic [7:0]                col_r_w, col_g_w, col_b_w;
    logic                      start_frame_w;

    // Fixed-point products rescaled to Q format, magnitude test and next z.
    assign zr2_w    = DATA_W'((PW'(zr_q) * PW'(zr_q)) >>> FRAC_W);
    assign zi2_w    = DATA_W'((PW'(zi_q) * PW'(zi_q)) >>> FRAC_W);
    assign zri_w    = DATA_W'((PW'(zr_q) * PW'(zi_q)) >>> FRAC_W);
    assign mag_w    = MW'(zr2_w) + MW'(zi2_w);
    assign escape_w = mag_w > ESC_LIM;
    assign zr_nxt_w = zr2_w - zi2_w + cr_q;
    assign zi_nxt_w = (zri_w <<< 1) + ci_q;

    // Escape colour ramp from the iteration count, wrapping at 8 bits.
    assign col_r_w = 8'(iter_q);
    assign col_g_w = col_r_w + col_r_w;
    assign col_b_w = col_g_w + col_r_w;

    assign out_stream.tdata  = tdata_q;
    assign out_stream.tkeep  = 4'hF;
    assign out_stream.tlast  = tlast_q;
    assign out_stream.tvalid = tvalid_q;
    assign out_stream.tuser  = tuser_q;
    assign busy              = busy_q;
    assign frame_done        = frame_done_q;

    // Next-state, pixel walk, iteration and registered stream outputs.
    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        iter_d        = iter_q;
        zr_d          = zr_q;
        zi_d          = zi_q;
        cr_d          = cr_q;
        ci_d          = ci_q;
        cre_acc_d     = cre_acc_q;
        cim_acc_d     = cim_acc_q;
        mode_d        = mode_q;
        max_iter_d    = max_iter_q;
        origin_re_d   = origin_re_q;
        step_d        = step_q;
        julia_re_d    = julia_re_q;
        julia_im_d    = julia_im_q;
        tdata_d       = tdata_q;
        tvalid_d      = tvalid_q;
        tlast_d       = tlast_q;
        tuser_d       = tuser_q;
        frame_done_d  = 1'b0;
        start_frame_w = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d       = S_INIT;
                    start_frame_w = 1'b1;
                end
            end
            S_INIT: begin
                iter_d  = '0;
                state_d = S_ITER;
                if (mode_q) begin
                    zr_d = cre_acc_q;
                    zi_d = cim_acc_q;
                    cr_d = julia_re_q;
                    ci_d = julia_im_q;
                end else begin
                    zr_d = '0;
                    zi_d = '0;
                    cr_d = cre_acc_q;
                    ci_d = cim_acc_q;
                end
            end
            S_ITER: begin
                if (escape_w || (iter_q == max_iter_q)) begin
                    state_d  = S_OUT;
                    tvalid_d = 1'b1;
                    tdata_d  = escape_w ? {8'h00, col_r_w, col_g_w, col_b_w} : 32'h0;
                    tuser_d  = (x_q == '0) && (y_q == '0);
                    tlast_d  = (x_q == X_LAST);
                end else begin
                    zr_d   = zr_nxt_w;
                    zi_d   = zi_nxt_w;
                    iter_d = iter_q + ITER_W'(1);
                end
            end
            S_OUT: begin
                if (out_stream.tready) begin
                    tvalid_d = 1'b0;
                    tuser_d  = 1'b0;
                    tlast_d  = 1'b0;
                    state_d  = S_INIT;
                    if (x_q == X_LAST) begin
                        x_d       = '0;
                        cre_acc_d = origin_re_q;
                        if (y_q == Y_LAST) begin
                            frame_done_d = 1'b1;
                            if (enable) begin
                                start_frame_w = 1'b1;
                            end else begin
                                state_d = S_IDLE;
                            end
                        end else begin
                            y_d       = y_q + YW'(1);
                            cim_acc_d = cim_acc_q + step_q;
                        end
                    end else begin
                        x_d       = x_q + XW'(1);
                        cre_acc_d = cre_acc_q + step_q;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Frame start: snapshot configuration and rewind to pixel (0,0).
        if (start_frame_w) begin
            mode_d      = mode;
            max_iter_d  = max_iter;
            origin_re_d = origin_re;
            step_d      = step;
            julia_re_d  = julia_re;
            julia_im_d  = julia_im;
            cre_acc_d   = origin_re;
            cim_acc_d   = origin_im;
            x_d         = '0;
            y_d         = '0;
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
        if (!periph_resetn) begin
            state_q      <= S_IDLE;
            x_q          <= '0;
            y_q          <= '0;
            iter_q       <= '0;
            zr_q         <= '0;
            zi_q         <= '0;
            cr_q         <= '0;
            ci_q         <= '0;
            cre_acc_q    <= '0;
            cim_acc_q    <= '0;
            mode_q       <= 1'b0;
            max_iter_q   <= '0;
            origin_re_q  <= '0;
            step_q       <= '0;
            julia_re_q   <= '0;
            julia_im_q   <= '0;
            tdata_q      <= '0;
            tvalid_q     <= 1'b0;
            tlast_q      <= 1'b0;
            tuser_q      <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            iter_q       <= iter_d;
            zr_q         <= zr_d;
            zi_q         <= zi_d;
            cr_q         <= cr_d;
            ci_q         <= ci_d;
            cre_acc_q    <= cre_acc_d;
            cim_acc_q    <= cim_acc_d;
            mode_q       <= mode_d;
            max_iter_q   <= max_iter_d;
            origin_re_q  <= origin_re_d;
            step_q       <= step_d;
            julia_re_q   <= julia_re_d;
            julia_im_q   <= julia_im_d;
            tdata_q      <= tdata_d;
            tvalid_q     <= tvalid_d;
            tlast_q      <= tlast_d;
            tuser_q      <= tuser_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

endmodule
